// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully connected layer with one shared MAC, activation and argmax
module dense_layer_seq #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACT   = 1,
  localparam int NC   = N_OUT * (N_IN + 1),
  localparam int AW   = $clog2(NC),
  localparam int OW   = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*DW-1:0]    in_vec,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [DW-1:0]         cfg_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_OUT*DW-1:0]   out_vec,
  output logic [OW-1:0]         out_argmax,
  output logic                  busy
);
  localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACCW = 2 * DW + $clog2(N_IN + 1);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;
  localparam logic signed [DW:0] HALF = (DW+1)'(2 ** (FRAC - 1));
  localparam logic signed [DW:0] ONE  = (DW+1)'(2 ** FRAC);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_ACT, S_DONE} state_t;

  state_t state, state_nx;
  logic signed [DW-1:0]   coef [NC];
  logic signed [DW-1:0]   in_reg [N_IN];
  logic signed [ACCW-1:0] acc, bias_acc, shr;
  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0]   r, hs, y, best;
  logic signed [DW:0]     h;
  logic [AW-1:0]          widx, bidx;
  logic [IW-1:0]          i;
  logic [OW-1:0]          o;

  assign in_ready  = state == S_IDLE && !cfg_we;
  assign out_valid = state == S_DONE;
  assign busy      = state != S_IDLE;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = (in_valid && in_ready) ? S_BIAS : S_IDLE;
      S_BIAS: state_nx = S_MAC;
      S_MAC:  state_nx = (i == IW'(N_IN - 1)) ? S_ACT : S_MAC;
      S_ACT:  state_nx = (o == OW'(N_OUT - 1)) ? S_DONE : S_BIAS;
      S_DONE: state_nx = out_ready ? S_IDLE : S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Coefficient o*(N_IN+1)+i is the weight; slot N_IN of each neuron holds its bias.
  always_comb begin
    widx     = AW'(o) * AW'(N_IN + 1) + AW'(i);
    bidx     = AW'(o) * AW'(N_IN + 1) + AW'(N_IN);
    prod     = (2*DW)'(in_reg[i]) * (2*DW)'(coef[widx]);
    bias_acc = ACCW'(coef[bidx]) <<< FRAC;
    shr      = acc >>> FRAC;
    r        = shr > MAXV ? {1'b0, {(DW-1){1'b1}}} : shr < MINV ? {1'b1, {(DW-1){1'b0}}} : shr[DW-1:0];
    h        = ($signed({r[DW-1], r}) >>> 2) + HALF;
    hs       = h < 0 ? '0 : h > ONE ? ONE[DW-1:0] : h[DW-1:0];
    y        = ACT == 0 ? r : ACT == 1 ? (r < 0 ? '0 : r) : hs;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int k = 0; k < NC; k++) coef[k] <= '0;
      for (int k = 0; k < N_IN; k++) in_reg[k] <= '0;
      acc        <= '0;
      i          <= '0;
      o          <= '0;
      best       <= '0;
      out_vec    <= '0;
      out_argmax <= '0;
    end else begin
      if (state == S_IDLE && cfg_we && {1'b0, cfg_addr} < (AW+1)'(NC)) coef[cfg_addr] <= cfg_wdata;
      if (state == S_IDLE && in_valid && in_ready) begin
        for (int k = 0; k < N_IN; k++) in_reg[k] <= in_vec[k*DW +: DW];
        o <= '0;
      end
      if (state == S_BIAS) begin
        acc <= bias_acc;
        i   <= '0;
      end
      if (state == S_MAC) begin
        acc <= acc + ACCW'(prod);
        i   <= i + 1'b1;
      end
      // Strict '>' keeps the lowest index on ties; neuron 0 seeds the running max.
      if (state == S_ACT) begin
        out_vec[o*DW +: DW] <= y;
        if (o == '0 || y > best) begin
          best       <= y;
          out_argmax <= o;
        end
        if (o != OW'(N_OUT - 1)) o <= o + 1'b1;
      end
    end
endmodule
